// File: rtl/regfile_scoreboard.sv
// Parametrised register file with combinational read ports and an integrated
// pending-write scoreboard used by ID to stall on in-flight producers.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wb_wr_en,
  input  logic [AW-1:0]     wb_wr_addr,
  input  logic [XLEN-1:0]   wb_wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic              sb_flush,
  output logic [AW:0]       busy_cnt,
  output logic              sb_idle
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;
  logic            sb_idle_q, sb_idle_d;
  logic            fwd;

  // Register 0 is never written; out-of-range addresses match no entry.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREG; r++) begin
      if (wb_wr_en && (wb_wr_addr == AW'(r))) begin
        regs_d[r] = wb_wr_data;
      end
    end
  end

  // A new issue supersedes a same-cycle writeback to the same register.
  always_comb begin
    pending_d = pending_q;
    if (sb_flush) begin
      pending_d = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_en && (iss_rd == AW'(r))) begin
          pending_d[r] = 1'b1;
        end else if (wb_wr_en && (wb_wr_addr == AW'(r))) begin
          pending_d[r] = 1'b0;
        end
      end
    end
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, pending_d[r]};
    end
    sb_idle_d = (busy_cnt_d == '0);
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    fwd     = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NRD; i++) begin
        for (int r = 1; r < NREG; r++) begin
          if (rd_addr[i*AW +: AW] == AW'(r)) begin
            fwd = (BYPASS != 0) && wb_wr_en && (wb_wr_addr == AW'(r));
            rd_data[i*XLEN +: XLEN] = fwd ? wb_wr_data : regs_q[r];
            rd_busy[i] = pending_q[r] && !fwd;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      pending_q  <= '0;
      busy_cnt_q <= '0;
      sb_idle_q  <= 1'b1;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pending_q  <= pending_d;
      busy_cnt_q <= busy_cnt_d;
      sb_idle_q  <= sb_idle_d;
    end
  end

  assign busy_cnt = busy_cnt_q;
  assign sb_idle  = sb_idle_q;

endmodule
